// File: rtl/mdr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdr_pkg
// Brief    : Shared types and constants for the memory data register control.
// Revision : 1.0 - initial release
// ============================================================================
package mdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } mdr_state_t;

    localparam logic [1:0] c_sz_byte  = 2'b00;
    localparam logic [1:0] c_sz_half  = 2'b01;
    localparam logic [1:0] c_sz_word  = 2'b10;
    localparam logic [1:0] c_sz_dword = 2'b11;

    // Wide enough for the largest legal TIMEOUT (255)
    localparam int c_cnt_w = 8;

endpackage
`default_nettype wire

// File: rtl/mdr_fmt.sv
`default_nettype none
// ============================================================================
// Module   : mdr_fmt
// Brief    : Little-endian field extraction with sign/zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module mdr_fmt
    import mdr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    input  logic [OFF_W-1:0]  i_off,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_shift;
    logic              w_msb;
    logic              w_fill;
    int                w_bits;

    always_comb begin
        w_shift = i_data >> {i_off, 3'b000};
        case (i_size)
            c_sz_byte: begin w_bits = 8;      w_msb = w_shift[7];        end
            c_sz_half: begin w_bits = 16;     w_msb = w_shift[15];       end
            c_sz_word: begin w_bits = 32;     w_msb = w_shift[31];       end
            default:   begin w_bits = DATA_W; w_msb = w_shift[DATA_W-1]; end
        endcase
        w_fill = i_signed & w_msb;
        o_data = '0;
        // Bits above the field take the fill value (sign bit or zero)
        for (int i = 0; i < DATA_W; i++) begin
            o_data[i] = (i < w_bits) ? w_shift[i] : w_fill;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdr_ctrl
// Brief    : Load data path controller: request, wait with timeout, capture.
// Revision : 1.0 - initial release
// ============================================================================
module mdr_ctrl
    import mdr_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int PHASE_W = 5,
    parameter  int W_IDX   = 3,
    parameter  int TIMEOUT = 16,
    localparam int OFF_W   = $clog2(DATA_W / 8)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] phase,
    input  logic [1:0]         ld_size,
    input  logic               ld_signed,
    input  logic [OFF_W-1:0]   ld_off,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_valid,
    output logic               mem_req,
    output logic [DATA_W-1:0]  mdr_out,
    output logic               mdr_valid,
    output logic               stall,
    output logic               err
);

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    mdr_state_t          r_state,  w_nxt_state;
    logic [c_cnt_w-1:0]  r_cnt,    w_nxt_cnt;
    logic [1:0]          r_size,   w_nxt_size;
    logic                r_signed, w_nxt_signed;
    logic [OFF_W-1:0]    r_off,    w_nxt_off;
    logic [DATA_W-1:0]   r_data,   w_nxt_data;
    logic                r_valid,  w_nxt_valid;
    logic                r_err,    w_nxt_err;
    logic                w_legal;
    logic [DATA_W-1:0]   w_fmt;
    logic                w_unused_phase;

    assign w_unused_phase = ^phase;

    mdr_fmt #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_fmt (
        .i_data   (mem_rdata),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_off    (r_off),
        .o_data   (w_fmt)
    );

    always_comb begin
        case (ld_size)
            c_sz_byte: w_legal = 1'b1;
            c_sz_half: w_legal = ~ld_off[0];
            c_sz_word: w_legal = (ld_off[1:0] == 2'b00);
            default:   w_legal = (DATA_W == 64) && (ld_off == '0);
        endcase
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cnt    = r_cnt;
        w_nxt_size   = r_size;
        w_nxt_signed = r_signed;
        w_nxt_off    = r_off;
        w_nxt_data   = r_data;
        w_nxt_valid  = r_valid;
        w_nxt_err    = 1'b0;
        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (phase[W_IDX]) begin
                    if (w_legal) begin
                        w_nxt_size   = ld_size;
                        w_nxt_signed = ld_signed;
                        w_nxt_off    = ld_off;
                        w_nxt_cnt    = '0;
                        w_nxt_valid  = 1'b0;
                        w_nxt_state  = ST_WAIT;
                    end else begin
                        w_nxt_err = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // Data arriving on the last allowed cycle still wins over timeout
                if (mem_valid) begin
                    w_nxt_data  = w_fmt;
                    w_nxt_valid = 1'b1;
                    w_nxt_state = ST_HOLD;
                end else if (r_cnt == c_cnt_last) begin
                    w_nxt_err   = 1'b1;
                    w_nxt_state = ST_IDLE;
                end else begin
                    w_nxt_cnt = r_cnt + c_cnt_w'(1);
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_off    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_size   <= w_nxt_size;
            r_signed <= w_nxt_signed;
            r_off    <= w_nxt_off;
            r_data   <= w_nxt_data;
            r_valid  <= w_nxt_valid;
            r_err    <= w_nxt_err;
        end
    end

    assign mem_req   = (r_state == ST_WAIT);
    assign stall     = (r_state == ST_WAIT);
    assign mdr_out   = r_data;
    assign mdr_valid = r_valid;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mdr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdr_ctrl
// Brief    : Directed self-checking bench for mdr_ctrl (32- and 64-bit builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdr_ctrl;

    localparam logic [4:0] c_ph = 5'b01000;

    logic        clk = 1'b0;
    logic        rst;

    logic [4:0]  phase;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic [1:0]  ld_off;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_req, mdr_valid, stall, err;
    logic [31:0] mdr_out;

    logic [4:0]  phase_64;
    logic [1:0]  ld_size_64;
    logic        ld_signed_64;
    logic [2:0]  ld_off_64;
    logic [63:0] mem_rdata_64;
    logic        mem_valid_64;
    logic        mem_req_64, mdr_valid_64, stall_64, err_64;
    logic [63:0] mdr_out_64;

    int n_total = 0;
    int n_pass  = 0;
    int stalls;
    int n;

    always #5 clk = ~clk;

    mdr_ctrl #(.DATA_W(32), .PHASE_W(5), .W_IDX(3), .TIMEOUT(16)) dut32 (
        .clk(clk), .rst(rst), .phase(phase), .ld_size(ld_size),
        .ld_signed(ld_signed), .ld_off(ld_off), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .mem_req(mem_req), .mdr_out(mdr_out),
        .mdr_valid(mdr_valid), .stall(stall), .err(err)
    );

    mdr_ctrl #(.DATA_W(64), .PHASE_W(5), .W_IDX(3), .TIMEOUT(16)) dut64 (
        .clk(clk), .rst(rst), .phase(phase_64), .ld_size(ld_size_64),
        .ld_signed(ld_signed_64), .ld_off(ld_off_64), .mem_rdata(mem_rdata_64),
        .mem_valid(mem_valid_64), .mem_req(mem_req_64), .mdr_out(mdr_out_64),
        .mdr_valid(mdr_valid_64), .stall(stall_64), .err(err_64)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    endtask

    // Issue one request, return mem_valid k cycles after the phase, count stall cycles
    task automatic load(input bit wide, input logic [1:0] sz, input logic sg,
                        input logic [2:0] off, input logic [63:0] rd, input int k,
                        output int st);
        st = 0;
        if (wide) begin
            phase_64 = c_ph; ld_size_64 = sz; ld_signed_64 = sg; ld_off_64 = off;
        end else begin
            phase = c_ph; ld_size = sz; ld_signed = sg; ld_off = off[1:0];
        end
        step();
        phase    = '0;
        phase_64 = '0;
        for (int i = 0; i < k; i++) begin
            if (i == k - 1) begin
                if (wide) begin mem_valid_64 = 1'b1; mem_rdata_64 = rd; end
                else begin mem_valid = 1'b1; mem_rdata = rd[31:0]; end
            end
            if ((wide ? stall_64 : stall) == 1'b1) st++;
            step();
        end
        mem_valid    = 1'b0;
        mem_valid_64 = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        phase = '0; ld_size = '0; ld_signed = 1'b0; ld_off = '0;
        mem_rdata = '0; mem_valid = 1'b0;
        phase_64 = '0; ld_size_64 = '0; ld_signed_64 = 1'b0; ld_off_64 = '0;
        mem_rdata_64 = '0; mem_valid_64 = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_mdr_out", mdr_out, 64'h0);
        check("rst_mdr_valid", mdr_valid, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_mdr_out_64", mdr_out_64, 64'h0);

        // Byte extraction, minimum latency
        load(1'b0, 2'b00, 1'b1, 3'd1, 64'h80FF7F01, 1, stalls);
        check("byte_s_off1", mdr_out, 64'h0000007F);
        check("byte_s_off1_valid", mdr_valid, 1'b1);
        check("min_latency_stalls", stalls, 1);
        check("hold_stall_low", stall, 1'b0);
        load(1'b0, 2'b00, 1'b1, 3'd2, 64'h80FF7F01, 1, stalls);
        check("byte_s_off2", mdr_out, 64'hFFFFFFFF);
        load(1'b0, 2'b00, 1'b0, 3'd3, 64'h80FF7F01, 1, stalls);
        check("byte_u_off3", mdr_out, 64'h00000080);

        // Half signed, memory answers 3 cycles after phase
        load(1'b0, 2'b01, 1'b1, 3'd2, 64'h80011234, 3, stalls);
        check("half_s_off2", mdr_out, 64'hFFFF8001);
        check("half_stall_cycles", stalls, 3);
        check("half_stall_after", stall, 1'b0);

        load(1'b0, 2'b10, 1'b0, 3'd0, 64'h12345678, 1, stalls);
        check("word_off0", mdr_out, 64'h12345678);

        // Timeout: no mem_valid
        phase = c_ph; ld_size = 2'b10; ld_signed = 1'b0; ld_off = 2'd0;
        step();
        phase = '0;
        check("to_entry_mem_req", mem_req, 1'b1);
        check("to_entry_valid_cleared", mdr_valid, 1'b0);
        n = 0;
        while (err !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("to_err_cycle", n, 16);
        check("to_mem_req_low", mem_req, 1'b0);
        check("to_mdr_out_kept", mdr_out, 64'h12345678);
        check("to_mdr_valid_low", mdr_valid, 1'b0);
        step();
        check("to_err_single", err, 1'b0);

        // Illegal requests
        phase = c_ph; ld_size = 2'b10; ld_off = 2'd2;
        step();
        phase = '0;
        check("ill_word_err", err, 1'b1);
        check("ill_word_mem_req", mem_req, 1'b0);
        step();
        check("ill_word_err_end", err, 1'b0);
        check("ill_word_mem_req2", mem_req, 1'b0);
        phase = c_ph; ld_size = 2'b11; ld_off = 2'd0;
        step();
        phase = '0;
        check("ill_dword32_err", err, 1'b1);
        check("ill_dword32_mem_req", mem_req, 1'b0);
        check("ill_dword32_out", mdr_out, 64'h12345678);

        // mem_valid outside WAIT is ignored
        mem_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        step();
        mem_valid = 1'b0;
        check("stray_valid_out", mdr_out, 64'h12345678);
        check("stray_valid_flag", mdr_valid, 1'b0);
        check("stray_valid_req", mem_req, 1'b0);

        // Phase during WAIT ignored (illegal controls must neither latch nor err)
        phase = c_ph; ld_size = 2'b00; ld_signed = 1'b0; ld_off = 2'd0;
        step();
        ld_size = 2'b11; ld_off = 2'd1;
        step();
        check("wait_phase_no_err", err, 1'b0);
        check("wait_phase_still_req", mem_req, 1'b1);
        phase = '0;
        mem_valid = 1'b1; mem_rdata = 32'hAABBCCDD;
        step();
        mem_valid = 1'b0;
        check("wait_phase_latched", mdr_out, 64'h000000DD);
        check("wait_phase_err_after", err, 1'b0);

        // Reset in second WAIT cycle, then a stray mem_valid
        phase = c_ph; ld_size = 2'b10; ld_signed = 1'b1; ld_off = 2'd0;
        step();
        phase = '0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_valid = 1'b1; mem_rdata = 32'h55555555;
        step();
        mem_valid = 1'b0;
        check("rstw_mdr_out", mdr_out, 64'h0);
        check("rstw_mdr_valid", mdr_valid, 1'b0);
        check("rstw_mem_req", mem_req, 1'b0);
        check("rstw_stall", stall, 1'b0);
        check("rstw_err", err, 1'b0);
        load(1'b0, 2'b00, 1'b0, 3'd0, 64'h000000A5, 2, stalls);
        check("rstw_next_out", mdr_out, 64'h000000A5);
        check("rstw_next_valid", mdr_valid, 1'b1);
        check("rstw_next_stalls", stalls, 2);

        // 64-bit build
        load(1'b1, 2'b11, 1'b0, 3'd0, 64'hFEDCBA9876543210, 1, stalls);
        check("w64_dword", mdr_out_64, 64'hFEDCBA9876543210);
        check("w64_dword_valid", mdr_valid_64, 1'b1);
        load(1'b1, 2'b10, 1'b1, 3'd4, 64'hFEDCBA9876543210, 1, stalls);
        check("w64_word_s_off4", mdr_out_64, 64'hFFFFFFFFFEDCBA98);
        load(1'b1, 2'b01, 1'b0, 3'd6, 64'hFEDCBA9876543210, 2, stalls);
        check("w64_half_u_off6", mdr_out_64, 64'h000000000000FEDC);
        phase_64 = c_ph; ld_size_64 = 2'b11; ld_off_64 = 3'd4;
        step();
        phase_64 = '0;
        check("w64_ill_dword_err", err_64, 1'b1);
        check("w64_ill_dword_req", mem_req_64, 1'b0);
        check("w64_ill_dword_out", mdr_out_64, 64'h000000000000FEDC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdr_ctrl.md
MDR_CTRL -- requirements
Module: mdr_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, memory data width; legal values 32 or 64.
REQ-002 Parameter PHASE_W, default 5, width of the phase vector.
REQ-003 Parameter W_IDX, default 3, index of the write-back (memory read capture) phase bit.
REQ-004 Parameter TIMEOUT, default 16, maximum cycles spent waiting for memory; legal range 2..255.
REQ-005 clk  input  1  the single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 phase  input  PHASE_W  one-hot CPU phase vector.
REQ-008 ld_size  input  2  access size: 00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_W=64).
REQ-009 ld_signed  input  1  1 = sign-extend, 0 = zero-extend.
REQ-010 ld_off  input  log2(DATA_W/8)  byte offset within the memory word.
REQ-011 mem_rdata  input  DATA_W  raw memory read data.
REQ-012 mem_valid  input  1  mem_rdata is valid this cycle.
REQ-013 mem_req  output  1  read request to memory.
REQ-014 mdr_out  output  DATA_W  formatted, extended load data.
REQ-015 mdr_valid  output  1  mdr_out holds the result of the latest completed load.
REQ-016 stall  output  1  CPU phase sequencer holds while asserted.
REQ-017 err  output  1  one-cycle error pulse.

Function
REQ-018 The controller SHALL implement states IDLE, WAIT and HOLD.
REQ-019 IDLE or HOLD with phase[W_IDX]=1 and a legal request: latch ld_size/ld_signed/ld_off, clear the timeout counter, clear mdr_valid, go to WAIT.
REQ-020 Illegal request (size 11 with DATA_W=32; half with ld_off[0]=1; word with ld_off[1:0]!=0; dword with ld_off!=0): err pulses for the next cycle, state and mdr_out unchanged, no mem_req.
REQ-021 mem_req and stall SHALL be 1 exactly while in WAIT.
REQ-022 WAIT with mem_valid=1: mdr_out <= formatted mem_rdata, mdr_valid <= 1, go to HOLD; result visible the cycle after mem_valid.
REQ-023 Formatting: select the size-wide field starting at byte ld_off (little-endian), then sign- or zero-extend to DATA_W using latched controls.
REQ-024 WAIT: the counter increments each cycle without mem_valid; on reaching TIMEOUT-1 without mem_valid, err pulses one cycle, mdr_out is unchanged, mdr_valid stays 0, go to IDLE.
REQ-025 mem_valid and timeout expiry in the same cycle: mem_valid wins, no err.
REQ-026 mem_valid outside WAIT SHALL be ignored.
REQ-027 phase[W_IDX] asserted while in WAIT SHALL be ignored (no re-latch, no err).
REQ-028 HOLD: mdr_out and mdr_valid held until the next accepted request or reset.
REQ-029 Minimum latency: phase at cycle N, mem_req at N+1, mem_valid at N+1, mdr_out valid at N+2.

Reset
REQ-030 On rst=1 at a clock edge: state IDLE, mdr_out 0, mdr_valid 0, mem_req 0, stall 0, err 0, counter 0, latched controls 0.
REQ-031 Reset in WAIT SHALL abandon the request with no err and no data capture.
REQ-032 rst SHALL take priority over all other inputs in the same cycle.

Structure
REQ-033 Package mdr_pkg SHALL hold the state enum, the ld_size code constants and the counter width constant.
REQ-034 Extraction and extension SHALL be a combinational sub-module mdr_fmt (inputs data, size, signed, off; output extended data); mdr_ctrl owns all registers.

Verification
REQ-035 DATA_W=32: mem_rdata=0x80FF7F01, byte, signed, off 1 -> mdr_out 0x0000007F; off 2 -> 0xFFFFFFFF; unsigned off 3 -> 0x00000080.
REQ-036 Half, signed, off 2, mem_rdata=0x8001_1234 -> 0xFFFF8001; mem_valid 3 cycles after phase -> stall high exactly 3 cycles.
REQ-037 No mem_valid -> err pulses once at TIMEOUT cycles after entry to WAIT, state IDLE, mdr_out keeps prior value 0x12345678.
REQ-038 Word with off 2, and size 11 with DATA_W=32 -> err pulse, mem_req never asserts.
REQ-039 rst asserted in the second cycle of WAIT, then mem_valid -> all outputs 0, no capture; next request completes normally.
REQ-040 DATA_W=64: dword off 0 with mem_rdata=0xFEDCBA9876543210 -> identical mdr_out; word signed off 4 -> 0xFFFFFFFFFEDCBA98.
